multi_7_seg_scan: RTL and testbench

Parametrised, time-multiplexed N-digit 7-segment driver for the scoreboard display. Decodes NUM_DIGITS 4-bit digit codes and scans them one at a time onto one shared segment bus with a one-hot digit enable. Adds tear-free frame snapshots, anti-ghosting guard cycles and leading-zero blanking. Sits between the score/BCD logic and the board pins, replacing per-digit static drivers.

---
 rtl/seg7_pkg.sv | 26 ++
 rtl/seg7_decode.sv | 31 +++
 rtl/multi_7_seg_scan.sv | 145 ++++++++++++++
 tb/tb_multi_7_seg_scan.sv | 126 ++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: segment patterns ({g,f,e,d,c,b,a}, active-high)
// and the special digit codes understood by seg7_decode.
package seg7_pkg;

    typedef logic [3:0] code_t;
    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'h00;
    localparam seg_t SEG_P     = 7'h73;
    localparam seg_t SEG_DASH  = 7'h40;

    localparam seg_t SEG_0 = 7'h3F;
    localparam seg_t SEG_1 = 7'h06;
    localparam seg_t SEG_2 = 7'h5B;
    localparam seg_t SEG_3 = 7'h4F;
    localparam seg_t SEG_4 = 7'h66;
    localparam seg_t SEG_5 = 7'h6D;
    localparam seg_t SEG_6 = 7'h7D;
    localparam seg_t SEG_7 = 7'h07;
    localparam seg_t SEG_8 = 7'h7F;
    localparam seg_t SEG_9 = 7'h6F;

    localparam code_t CODE_BLANK = 4'd10;
    localparam code_t CODE_P     = 4'd11;

endpackage

// File: rtl/seg7_decode.sv
// Combinational digit-code to 7-segment pattern decoder.
// Codes 0..9 are decimal digits, 10 is blank, 11 is 'P', 12..15 show '-'.
module seg7_decode
    import seg7_pkg::*;
(
    input  code_t code,
    output seg_t  seg
);

    // Map one 4-bit code onto its segment pattern.
    always_comb begin
        // NOTE: assigning a default before the case guarantees every path drives seg, so no latch is inferred.
        seg = SEG_DASH;
        case (code)
            4'd0:       seg = SEG_0;
            4'd1:       seg = SEG_1;
            4'd2:       seg = SEG_2;
            4'd3:       seg = SEG_3;
            4'd4:       seg = SEG_4;
            4'd5:       seg = SEG_5;
            4'd6:       seg = SEG_6;
            4'd7:       seg = SEG_7;
            4'd8:       seg = SEG_8;
            4'd9:       seg = SEG_9;
            CODE_BLANK: seg = SEG_BLANK;
            CODE_P:     seg = SEG_P;
            default:    seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/multi_7_seg_scan.sv
// Time-multiplexed N-digit 7-segment scanner.
// Digits are captured once per frame (tear-free), scanned 0..N-1 onto a shared
// segment bus with a one-hot digit enable, a guard gap at the start of each slot
// and optional leading-zero blanking.
// Optional blink support is built when MULTI_7_SEG_BLINK_EN is defined.
module multi_7_seg_scan
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned SCAN_DIV     = 1000,
    parameter int unsigned GUARD_CYCLES = 1
`ifdef MULTI_7_SEG_BLINK_EN
   ,parameter int unsigned BLINK_FRAMES = 64
`endif
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic [4*NUM_DIGITS-1:0] digits_i,
    input  logic                    lz_blank_i,
`ifdef MULTI_7_SEG_BLINK_EN
    input  logic [NUM_DIGITS-1:0]   blink_mask_i,
`endif
    output logic [6:0]              seg_o,
    output logic [NUM_DIGITS-1:0]   digit_en_o,
    output logic                    frame_start_o
);

    localparam int unsigned PRE_W = $clog2(SCAN_DIV);
    localparam int unsigned IDX_W = $clog2(NUM_DIGITS);

    localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(SCAN_DIV - 1);
    localparam logic [PRE_W-1:0] GUARD_VAL = PRE_W'(GUARD_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] ONE_HOT0 = NUM_DIGITS'(1);

    logic [PRE_W-1:0]      pre_cnt;
    logic [IDX_W-1:0]      idx;
    code_t                 snap [NUM_DIGITS];
    logic                  lz_snap;
    logic                  slot_end;
    logic                  frame_end;
    logic [NUM_DIGITS-1:0] blank_vec;
    code_t                 cur_code;
    seg_t                  dec_seg;
    seg_t                  seg_next;
    logic [NUM_DIGITS-1:0] en_next;

    assign slot_end  = (pre_cnt == PRE_LAST);
    assign frame_end = slot_end && (idx == IDX_LAST);

    // Slot prescaler and digit index: idx advances once per SCAN_DIV cycles.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pre_cnt <= '0;
            idx     <= '0;
        end else if (slot_end) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            pre_cnt <= '0;
            idx     <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end

    // Frame snapshot: digits and blanking mode are captured only on the last frame cycle.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            // NOTE: the snapshot is a small flop array, not a RAM, so it is reset to blank to keep the first frame dark.
            for (int k = 0; k < NUM_DIGITS; k++) snap[k] <= CODE_BLANK;
            lz_snap <= 1'b0;
        end else if (frame_end) begin
            for (int k = 0; k < NUM_DIGITS; k++) snap[k] <= digits_i[4*k +: 4];
            lz_snap <= lz_blank_i;
        end
    end

    // Leading-zero mask: digit k>0 blanks when it and every higher digit hold code 0.
    always_comb begin
        logic above_zero;
        blank_vec  = '0;
        // NOTE: above_zero is a running combinational value, so it uses blocking assignments inside the loop.
        above_zero = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            above_zero   = above_zero && (snap[k] == 4'd0);
            blank_vec[k] = lz_snap && above_zero;
        end
    end

    assign cur_code = snap[idx];

    seg7_decode u_decode (
        .code (cur_code),
        .seg  (dec_seg)
    );

`ifdef MULTI_7_SEG_BLINK_EN
    localparam int unsigned FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(BLINK_FRAMES - 1);

    logic [FC_W-1:0] frame_cnt;
    logic            blink_phase;

    // Blink timebase: counts snapshot events and flips the phase every BLINK_FRAMES frames.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (frame_end) begin
            if (frame_cnt == FC_LAST) begin
                frame_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end
`endif

    // Next segment pattern: decoded digit, then leading-zero and blink suppression.
    always_comb begin
        seg_next = blank_vec[idx] ? SEG_BLANK : dec_seg;
`ifdef MULTI_7_SEG_BLINK_EN
        if (blink_phase && blink_mask_i[idx]) seg_next = SEG_BLANK;
`endif
    end

    // Digit enable stays low for the first GUARD_CYCLES of each slot to prevent ghosting.
    always_comb begin
        en_next = (pre_cnt >= GUARD_VAL) ? (ONE_HOT0 << idx) : '0;
    end

    // Registered outputs, one cycle behind the counters.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            seg_o         <= SEG_BLANK;
            digit_en_o    <= '0;
            frame_start_o <= 1'b0;
        end else begin
            seg_o         <= seg_next;
            digit_en_o    <= en_next;
            frame_start_o <= (idx == '0) && (pre_cnt == '0);
        end
    end

endmodule

// File: tb/tb_multi_7_seg_scan.sv
// Directed bench for multi_7_seg_scan (4 digits, 4-cycle slots, 1 guard cycle).
// Each frame is checked cycle by cycle against hand-computed patterns.
// With MULTI_7_SEG_BLINK_EN defined, digit 1 blinks with a 2-frame half-period.
module tb_multi_7_seg_scan;

    logic        clk = 1'b0;
    logic        rst_n_i;
    logic [15:0] digits_i;
    logic        lz_blank_i;
    logic [6:0]  seg_o;
    logic [3:0]  digit_en_o;
    logic        frame_start_o;
`ifdef MULTI_7_SEG_BLINK_EN
    logic [3:0]  blink_mask_i = 4'b0010;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int frame_no = 0;

    always #5 clk = ~clk;

    multi_7_seg_scan #(
        .NUM_DIGITS   (4),
        .SCAN_DIV     (4),
        .GUARD_CYCLES (1)
`ifdef MULTI_7_SEG_BLINK_EN
       ,.BLINK_FRAMES (2)
`endif
    ) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n_i),
        .digits_i      (digits_i),
        .lz_blank_i    (lz_blank_i),
`ifdef MULTI_7_SEG_BLINK_EN
        .blink_mask_i  (blink_mask_i),
`endif
        .seg_o         (seg_o),
        .digit_en_o    (digit_en_o),
        .frame_start_o (frame_start_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Walk one 16-cycle frame; exp_segs = {d3,d2,d1,d0}. New inputs are driven mid-frame.
    task automatic run_frame(input logic [27:0] exp_segs, input logic [15:0] nxt_digits,
                             input logic nxt_lz);
        logic [6:0] e_seg;
        logic [3:0] e_en;
        logic [3:0] one;
        int d, s;
        one = 4'b0001;
        for (int p = 0; p < 16; p++) begin
            @(posedge clk);
            @(negedge clk);
            d = p / 4;
            s = p % 4;
            e_seg = exp_segs[7*d +: 7];
`ifdef MULTI_7_SEG_BLINK_EN
            if (d == 1 && ((frame_no / 2) % 2) == 1) e_seg = 7'h00;
`endif
            e_en = (s >= 1) ? (one << d) : 4'b0000;
            check($sformatf("f%0d p%0d seg", frame_no, p), 32'(seg_o), 32'(e_seg));
            check($sformatf("f%0d p%0d en", frame_no, p), 32'(digit_en_o), 32'(e_en));
            check($sformatf("f%0d p%0d fs", frame_no, p), 32'(frame_start_o), 32'(p == 0));
            if (p == 8) begin
                digits_i   = nxt_digits;
                lz_blank_i = nxt_lz;
            end
        end
        frame_no++;
    endtask

    initial begin
        rst_n_i    = 1'b0;
        digits_i   = 16'h0000;
        lz_blank_i = 1'b0;
        #1;
        check("reset seg", 32'(seg_o), 32'h00);
        check("reset en",  32'(digit_en_o), 32'h0);
        check("reset fs",  32'(frame_start_o), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n_i = 1'b1;

        // Frame 0 blank (reset snapshot); then basic digits, blanking, tear-free change, codes.
        run_frame({7'h00, 7'h00, 7'h00, 7'h00}, 16'h4321, 1'b0);
        run_frame({7'h66, 7'h4F, 7'h5B, 7'h06}, 16'h0050, 1'b1);
        run_frame({7'h00, 7'h00, 7'h6D, 7'h3F}, 16'h0050, 1'b0);
        run_frame({7'h3F, 7'h3F, 7'h6D, 7'h3F}, 16'h1111, 1'b0);
        run_frame({7'h06, 7'h06, 7'h06, 7'h06}, 16'h2222, 1'b0);
        run_frame({7'h5B, 7'h5B, 7'h5B, 7'h5B}, 16'hFCBA, 1'b0);
        run_frame({7'h40, 7'h40, 7'h73, 7'h00}, 16'h0A00, 1'b1);
        run_frame({7'h00, 7'h00, 7'h3F, 7'h3F}, 16'h0000, 1'b1);
        run_frame({7'h00, 7'h00, 7'h00, 7'h3F}, 16'h1234, 1'b0);

        // Partial frame showing 1234, then reset asserted mid-slot away from any edge.
        for (int p = 0; p < 6; p++) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("pre-rst seg", 32'(seg_o), 32'h4F);
        check("pre-rst en",  32'(digit_en_o), 32'h2);
        #2;
        rst_n_i = 1'b0;
        #1;
        check("async seg", 32'(seg_o), 32'h00);
        check("async en",  32'(digit_en_o), 32'h0);
        check("async fs",  32'(frame_start_o), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n_i  = 1'b1;
        frame_no = 0;

        run_frame({7'h00, 7'h00, 7'h00, 7'h00}, 16'h1234, 1'b0);
        run_frame({7'h06, 7'h5B, 7'h4F, 7'h66}, 16'h1234, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
